// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative shift-add multiply / restoring divide unit for the EX stage
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [4:0]       RD,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [4:0]       rd_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [4:0]         rd_q, rd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               sign1_q, sign1_d, sign2_q, sign2_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [4:0]         rd_out_q, rd_out_d;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // op[0] selects signed; op[1] selects divide
    assign mag1 = (op[0] && data_1[WIDTH-1]) ? -data_1 : data_1;
    assign mag2 = (op[0] && data_2[WIDTH-1]) ? -data_2 : data_2;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // acc holds {partial remainder, dividend/quotient}; the dropped shift MSB can only be set when the trial succeeds
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb_q};
    assign div_next  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = (op_q[0] && (sign1_q ^ sign2_q)) ? -acc_q : acc_q;
    assign quo_fix  = (op_q[0] && (sign1_q ^ sign2_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = (op_q[0] && sign1_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(WIDTH - 1);
                    op_d    = op;
                    rd_d    = RD;
                    sign1_d = op[0] & data_1[WIDTH-1];
                    sign2_d = op[0] & data_2[WIDTH-1];
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, mag1};
                        opb_d = mag2;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag2};
                        opb_d = mag1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d  = S_DONE;
                rd_out_d = rd_q;
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = (opb_q == '0) ? '1 : quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign rd_out = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed-vector bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    logic        CLOCK;
    logic        RESET_N;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_1, data_2;
    logic [4:0]  RD;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .op(op),
        .data_1(data_1), .data_2(data_2), .RD(RD),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .rd_out(rd_out)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Returns at the negedge where done is first seen (or after a 100-cycle bound).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input bit b2b, input int inj,
                          output int lat, output int bcnt);
        if (!b2b) @(negedge CLOCK);
        start = 1'b1; op = o; data_1 = a; data_2 = b; RD = r;
        @(negedge CLOCK);
        start = 1'b0; data_1 = 32'hDEADBEEF; data_2 = 32'h0BADF00D; RD = 5'd17;
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            if (lat == inj) begin
                start = 1'b1; op = 2'b00; data_1 = 32'd1; data_2 = 32'd1; RD = 5'd31;
            end else begin
                start = 1'b0;
            end
            @(negedge CLOCK);
            lat++;
            if (busy) bcnt++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; start = 1'b0; op = 2'b00; data_1 = '0; data_2 = '0; RD = '0;
        repeat (3) @(negedge CLOCK);
        checks++;
        if ({busy, done, hi, lo, rd_out} !== 71'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h rd=%0d expected all zero",
                     busy, done, hi, lo, rd_out);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_multu;
        int lat, bcnt;
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1'b0, 0, lat, bcnt);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL multu_latency got %0d expected 34", lat); end
        checks++;
        if (bcnt !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d expected 33", bcnt); end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || rd_out !== 5'd5) begin
            errors++;
            $display("FAIL multu_result hi=%h lo=%h rd=%0d expected fffffffe 00000001 5", hi, lo, rd_out);
        end
        @(negedge CLOCK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse_width done=%b busy=%b expected 0 0", done, busy);
        end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++; $display("FAIL result_hold hi=%h lo=%h expected fffffffe 00000001", hi, lo);
        end
    endtask

    task automatic test_mult;
        int lat, bcnt;
        run_op(2'b01, 32'hFFFFFFFD, 32'd7, 5'd1, 1'b0, 0, lat, bcnt);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB || lat !== 34) begin
            errors++; $display("FAIL mult_neg hi=%h lo=%h lat=%0d expected ffffffff ffffffeb 34", hi, lo, lat);
        end
    endtask

    task automatic test_div;
        int lat, bcnt;
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 5'd2, 1'b0, 0, lat, bcnt);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_neg hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
        end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b0, 0, lat, bcnt);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            errors++; $display("FAIL div_overflow hi=%h lo=%h expected 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        run_op(2'b10, 32'd100, 32'd0, 5'd7, 1'b0, 0, lat, bcnt);
        checks++;
        if (hi !== 32'h64 || lo !== 32'hFFFFFFFF || lat !== 34 || rd_out !== 5'd7) begin
            errors++;
            $display("FAIL divu_zero hi=%h lo=%h lat=%0d rd=%0d expected 00000064 ffffffff 34 7", hi, lo, lat, rd_out);
        end
        run_op(2'b11, 32'hFFFFFFF9, 32'd0, 5'd8, 1'b0, 0, lat, bcnt);
        checks++;
        if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL div_zero_signed hi=%h lo=%h expected fffffff9 ffffffff", hi, lo);
        end
    endtask

    task automatic test_start_ignored;
        int lat, bcnt;
        run_op(2'b00, 32'd6, 32'd7, 5'd9, 1'b0, 10, lat, bcnt);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42 || rd_out !== 5'd9 || lat !== 34) begin
            errors++;
            $display("FAIL start_while_busy hi=%h lo=%h rd=%0d lat=%0d expected 0 2a 9 34", hi, lo, rd_out, lat);
        end
    endtask

    task automatic test_reset_mid;
        int seen_done, seen_busy;
        @(negedge CLOCK);
        start = 1'b1; op = 2'b00; data_1 = 32'd3; data_2 = 32'd5; RD = 5'd12;
        @(negedge CLOCK);
        start = 1'b0;
        repeat (19) @(negedge CLOCK);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_run got %b expected 1", busy); end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo, rd_out} !== 71'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h rd=%0d expected all zero",
                     busy, done, hi, lo, rd_out);
        end
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        seen_done = 0; seen_busy = 0;
        repeat (40) begin
            @(negedge CLOCK);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        checks++;
        if (seen_done !== 0 || seen_busy !== 0) begin
            errors++; $display("FAIL after_reset_idle done_cycles=%0d busy_cycles=%0d expected 0 0", seen_done, seen_busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        run_op(2'b10, 32'd100, 32'd7, 5'd3, 1'b0, 0, lat, bcnt);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14 || rd_out !== 5'd3) begin
            errors++; $display("FAIL b2b_first hi=%h lo=%h rd=%0d expected 2 e 3", hi, lo, rd_out);
        end
        run_op(2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 5'd4, 1'b1, 0, lat, bcnt);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL b2b_interval got %0d expected 34", lat); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd6 || rd_out !== 5'd4) begin
            errors++; $display("FAIL b2b_second hi=%h lo=%h rd=%0d expected 0 6 4", hi, lo, rd_out);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide execution unit on the consumer side of the ID/EX pipeline register. It accepts the two source operands and destination register number that the ID/EX stage presents and computes a 64-bit product or a quotient/remainder pair over multiple cycles. It raises `busy` so that hazard logic holds ID/EX and the front end. On completion it returns HI/LO plus the carried destination tag toward writeback.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.

- `CLOCK`  in  1  rising-edge clock for all state.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  ID/EX holds a valid mul/div op; sampled only when idle.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `data_1`  in  WIDTH  rs operand: multiplicand or dividend.
- `data_2`  in  WIDTH  rt operand: multiplier or divisor.
- `RD`  in  5  destination tag, carried unchanged.
- `busy`  out  1  operation in flight; stall request.
- `done`  out  1  one-cycle pulse; `hi`/`lo`/`rd_out` are valid from this cycle.
- `hi`  out  WIDTH  product upper half, or remainder.
- `lo`  out  WIDTH  product lower half, or quotient.
- `rd_out`  out  5  tag of the completed operation.

## Operation
- State machine: IDLE, RUN, FIX, DONE.
  - IDLE → RUN: when `start`=1. Capture `op` and `RD`. Capture the magnitudes of `data_1` and `data_2`; signed ops take two's-complement absolute values, unsigned ops take the raw values. Record the sign bits.
  - RUN → FIX: after exactly `WIDTH` iterations, counted by a counter that loads `WIDTH-1` and decrements to 0.
  - FIX → DONE: apply sign correction and write `hi`, `lo`, `rd_out`.
  - DONE → RUN: if `start`=1 (back-to-back accept).
  - DONE → IDLE: otherwise.
- Multiply uses shift-add, one multiplier bit per cycle, into a 2·`WIDTH` accumulator.
  - MULT: if the two signs differ, the 64-bit product is negated in FIX.
- Divide uses restoring division, one quotient bit per cycle.
  - DIV quotient sign = sign1 XOR sign2.
  - DIV remainder sign = sign of the dividend.
- Divide by zero, checked in FIX, either signedness: `hi` = original `data_1`, `lo` = all ones. Full latency still applies.
- Signed overflow, −2^WIDTH−1 / −1: `lo` = 0x80000000, `hi` = 0. This is the natural result of the magnitude path; no special case is needed.
- `start` while `busy`=1 is ignored. No operand is latched and no state changes.
- `hi`, `lo`, `rd_out` hold their last completed values until the next FIX.
- `busy` = 1 in RUN and FIX only.
- `done` = 1 in DONE only.

## Timing
- Reset, asynchronous and immediate on `RESET_N`=0: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `rd_out`=0, counter 0. No partial result is ever exposed.
- Reset mid-operation aborts the operation. After release, the unit waits in IDLE.
- Cycle numbering: edge 0 samples `start`=1.
  - `busy` is high from after edge 0 through edge `WIDTH`+1.
  - Results are registered at edge `WIDTH`+1.
  - `done` is high for the single cycle after edge `WIDTH`+1.
- Total latency from start edge to `done` = `WIDTH`+2 cycles, i.e. 34 for the default.
- Back-to-back: a `start` in the DONE cycle is accepted at the next edge, which also clears `done`. Issue interval = `WIDTH`+2 cycles.
- Operand inputs need be stable only at the accepting edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, `RD`=5 → after 34 cycles: `done` pulse, `hi`=0xFFFFFFFE, `lo`=0x00000001, `rd_out`=5. `busy` high for exactly 33 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV −7 / 2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- DIVU 100 / 0 → `hi`=0x00000064, `lo`=0xFFFFFFFF, same 34-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Control cases:
  - Pulse `start` with new operands at cycle 10 of a run → ignored; the original result is returned.
  - Assert `RESET_N`=0 at cycle 20 → `busy`, `done`, `hi`, `lo`, `rd_out` go to 0 immediately; no `done` pulse follows.
  - After reset release, two back-to-back ops with `start` held in the DONE cycle → two `done` pulses 34 cycles apart.
